mcu_bus_arbiter: RTL and testbench
==================================

# mcu_bus_arbiter

Parametrised N-master bus arbiter sitting between the CPU-side bus masters (CPU core, future DMA/debug ports) and the single memory controller port of the MCU top level. It accepts one request per master, selects one by round-robin, issues it to the memory side with a req/ack handshake supporting arbitrary wait states, and returns read data and error status to the granted master. Generalises the current single-master, zero-wait CPU-to-memory wiring to multiple masters and a stalling memory.

## Interface
- NUM_MASTERS, 2, number of master ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, slave-response timeout in cycles (used only with timeout feature; 1..65535)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- m_req  in  NUM_MASTERS  per-master request, level, held until matching m_ack
- m_write  in  NUM_MASTERS  per-master write (1) / read (0)
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data, same packing
- m_ack  out  NUM_MASTERS  one-cycle completion pulse, at most one bit set
- m_error  out  NUM_MASTERS  error flag, valid only with corresponding m_ack
- m_rdata  out  DATA_W  shared read data, valid with any m_ack
- grant_id  out  $clog2(NUM_MASTERS)  index of master currently/last served
- s_req  out  1  request to memory controller
- s_write  out  1  write strobe to memory controller
- s_addr  out  ADDR_W  address to memory controller
- s_wdata  out  DATA_W  write data to memory controller
- s_ack  in  1  one-cycle completion from memory controller, only honoured while s_req=1
- s_rdata  in  DATA_W  read data, valid with s_ack
- s_error  in  1  error, valid with s_ack

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any m_req bit set, pick first set bit searching upward from last_grant+1 (wrapping mod NUM_MASTERS); latch its write/addr/wdata into s_write/s_addr/s_wdata, set s_req=1, grant_id=winner, go BUSY. No request: stay IDLE, s_req=0.
- BUSY: s_req and s_* held stable. On s_ack: register s_rdata→m_rdata, s_error→m_error[g], set m_ack[g]=1, s_req=0, last_grant=g, go RESP.
- RESP: m_ack/m_error deasserted next cycle; go IDLE. m_rdata holds value until next completion.
- Master inputs are sampled only in IDLE; changes during BUSY have no effect. A master dropping m_req mid-transaction still receives its m_ack (master ignores it).
- Write transactions return m_rdata = s_rdata as presented (don't-care to masters).
- Simultaneous requests: only the round-robin winner is served; others stay pending. With all masters continuously requesting, each is served once per NUM_MASTERS transactions.
- Reset (any time, including BUSY): state=IDLE, last_grant=NUM_MASTERS-1 (master 0 wins first), s_req=0, s_write=0, s_addr=0, s_wdata=0, m_ack=0, m_error=0, m_rdata=0, grant_id=0. An in-flight slave transaction is abandoned.

## Timing
- m_req seen high in IDLE at edge T → s_req high after T.
- s_ack sampled at edge T+k (k≥1) → m_ack high for exactly one cycle after T+k.
- Minimum transaction period 3 cycles (IDLE→BUSY→RESP); zero-wait slave: req-to-ack latency 2 cycles.
- All outputs registered; no combinational path from any input to any output.

## Configuration
- ARB_TIMEOUT_EN defined: a counter (width sufficient for TIMEOUT_CYCLES) clears on entering BUSY and increments each BUSY cycle; if it reaches TIMEOUT_CYCLES with no s_ack, drop s_req, go RESP with m_ack[g]=1, m_error[g]=1, m_rdata=0. s_ack on the same edge as the timeout wins (normal completion).
- Not defined: no counter; BUSY waits indefinitely for s_ack.

## Test plan
- Single read: master 0 reads 0x100, slave acks after 3 wait cycles with 0xDEADBEEF → s_addr=0x100, m_ack[0] one cycle, m_rdata=0xDEADBEEF, m_error=0.
- Contention: masters 0 and 1 request continuously after reset, zero-wait slave → grant order 0,1,0,1; each m_ack 3 cycles apart.
- Error pass-through: master 1 write to 0xFFFF0000, slave acks with s_error=1 → m_ack[1]=1, m_error[1]=1 same cycle, m_error[0]=0.
- Reset mid-BUSY: assert rst low while s_req=1 → all outputs 0 immediately; after release, master 0 wins first.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks → m_ack with m_error=1 and m_rdata=0 after 8 BUSY cycles; without the macro, s_req stays high for 100+ cycles.

Source files
------------

// File: rtl/mcu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mcu_bus_arbiter
//
// Round-robin arbiter between NUM_MASTERS CPU-side bus masters and the single
// memory controller port. One transaction is in flight at a time. The winner's
// write/addr/wdata are registered onto the s_* side and held while the memory
// controller inserts wait states. Read data and error status come back to the
// granted master as a one-cycle m_ack pulse.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   m_req/m_write   per-master request level and direction (1 = write)
//   m_addr/m_wdata  packed per-master address / write data, master i at
//                   [i*W +: W]
//   m_ack/m_error   one-cycle completion pulse and error flag per master
//   m_rdata         shared read data, valid with any m_ack, held until the
//                   next completion
//   grant_id        index of the master currently or last served
//   s_req/s_write/s_addr/s_wdata   request to the memory controller
//   s_ack/s_rdata/s_error          completion from the memory controller
//
// Optional feature
//   ARB_TIMEOUT_EN  when defined, a transaction with no s_ack for
//                   TIMEOUT_CYCLES busy cycles is completed locally with
//                   m_error=1 and m_rdata=0. When undefined, BUSY waits for
//                   s_ack indefinitely.
//
// Every output is registered, so there is no combinational path from any
// input to any output.
// -----------------------------------------------------------------------------
module mcu_bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_MASTERS-1:0]          m_req,
   input  logic [NUM_MASTERS-1:0]          m_write,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [NUM_MASTERS-1:0]          m_ack,
   output logic [NUM_MASTERS-1:0]          m_error,
   output logic [DATA_W-1:0]               m_rdata,
   output logic [$clog2(NUM_MASTERS)-1:0]  grant_id,
   output logic                            s_req,
   output logic                            s_write,
   output logic [ADDR_W-1:0]               s_addr,
   output logic [DATA_W-1:0]               s_wdata,
   input  logic                            s_ack,
   input  logic [DATA_W-1:0]               s_rdata,
   input  logic                            s_error
);

   localparam int GW = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
      $error("mcu_bus_arbiter: NUM_MASTERS must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mcu_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [GW-1:0]          last_grant;
   logic [GW-1:0]          winner;
   logic                   any_req;
   logic [NUM_MASTERS-1:0] grant_onehot;
   logic                   timeout;

   // Round-robin pick: the first requesting master above last_grant, wrapping.
   // NOTE: every variable written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      int  idx;
      logic found;
      winner       = '0;
      found        = 1'b0;
      idx          = 0;
      any_req      = |m_req;
      grant_onehot = '0;
      grant_onehot[grant_id] = 1'b1;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(last_grant) + i) % NUM_MASTERS;
         if (!found && m_req[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // Counts completed BUSY cycles of the current transaction. It is held at
   // zero outside BUSY, so it starts from zero on every entry to BUSY.
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              tmo_cnt <= '0;
      else if (state != BUSY) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + 1'b1;
   end

   // The edge that closes the TIMEOUT_CYCLES-th busy cycle; an s_ack on that
   // same edge takes priority (checked first in the datapath).
   assign timeout = (state == BUSY) && !s_ack &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (any_req) state_next = BUSY;
         BUSY:    if (s_ack || timeout) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered datapath. Reset abandons any in-flight slave transaction.
   // NOTE: these are ordinary control/data registers, not a memory array, so
   // all of them are reset to give a defined bus state straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= GW'(NUM_MASTERS - 1);
         grant_id   <= '0;
         s_req      <= 1'b0;
         s_write    <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         m_ack      <= '0;
         m_error    <= '0;
         m_rdata    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  s_req    <= 1'b1;
                  s_write  <= m_write[winner];
                  s_addr   <= m_addr[winner*ADDR_W +: ADDR_W];
                  s_wdata  <= m_wdata[winner*DATA_W +: DATA_W];
                  grant_id <= winner;
               end
            end
            BUSY: begin
               if (s_ack) begin
                  s_req      <= 1'b0;
                  m_rdata    <= s_rdata;
                  m_ack      <= grant_onehot;
                  m_error    <= s_error ? grant_onehot : '0;
                  last_grant <= grant_id;
               end else if (timeout) begin
                  s_req      <= 1'b0;
                  m_rdata    <= '0;
                  m_ack      <= grant_onehot;
                  m_error    <= grant_onehot;
                  last_grant <= grant_id;
               end
            end
            RESP: begin
               m_ack   <= '0;
               m_error <= '0;
            end
            default: begin
               m_ack   <= '0;
               m_error <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mcu_bus_arbiter
//
// Directed bench for mcu_bus_arbiter with two masters. A small slave model
// acknowledges s_req after a programmable number of wait cycles (or never).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mcu_bus_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_req;
   logic [N-1:0]      m_write;
   logic [N*AW-1:0]   m_addr;
   logic [N*DW-1:0]   m_wdata;
   logic [N-1:0]      m_ack;
   logic [N-1:0]      m_error;
   logic [DW-1:0]     m_rdata;
   logic [0:0]        grant_id;
   logic              s_req;
   logic              s_write;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic              s_ack;
   logic [DW-1:0]     slave_rdata;
   logic              slave_err;

   // Slave model controls.
   logic              slave_en;
   int                slave_wait;
   int                busy_cnt;

   int checks = 0;
   int errors = 0;

   mcu_bus_arbiter #(
      .NUM_MASTERS    (N),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_req    (m_req),
      .m_write  (m_write),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_ack    (m_ack),
      .m_error  (m_error),
      .m_rdata  (m_rdata),
      .grant_id (grant_id),
      .s_req    (s_req),
      .s_write  (s_write),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_ack    (s_ack),
      .s_rdata  (slave_rdata),
      .s_error  (slave_err)
   );

   always #5 clk = ~clk;

   // Slave: pulses s_ack for one cycle once s_req has been seen high on
   // slave_wait earlier falling edges.
   initial begin
      s_ack    = 1'b0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (s_req && !s_ack && slave_en && busy_cnt >= slave_wait) s_ack = 1'b1;
         else                                                      s_ack = 1'b0;
         busy_cnt = s_req ? busy_cnt + 1 : 0;
      end
   end

   // Waits up to limit falling edges for any m_ack; cycles = limit+1 on expiry.
   task automatic wait_ack(input int limit, output int cycles);
      cycles = limit + 1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (m_ack != '0) begin
            cycles = c;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      m_req = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req got %b want 0", s_req); end
      checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_m_ack got %b want 00", m_ack); end
      checks++; if (m_error !== 2'b00) begin errors++; $display("FAIL reset_m_error got %b want 00", m_error); end
      checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got %h want 0", m_rdata); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
      checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_s_addr got %h want 0", s_addr); end
      rst = 1'b1;
   endtask

   task automatic test_single_read();
      int cyc;
      slave_en    = 1'b1;
      slave_wait  = 3;
      slave_rdata = 32'hDEADBEEF;
      slave_err   = 1'b0;
      m_write     = 2'b00;
      m_addr[0 +: AW] = 32'h0000_0100;
      m_req       = 2'b01;
      @(negedge clk);
      checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL read_s_req got %b want 1", s_req); end
      checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL read_s_addr got %h want 00000100", s_addr); end
      checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL read_s_write got %b want 0", s_write); end
      wait_ack(20, cyc);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL read_latency got %0d want 4", cyc); end
      checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL read_m_ack got %b want 01", m_ack); end
      checks++; if (m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m_rdata got %h want deadbeef", m_rdata); end
      checks++; if (m_error !== 2'b00) begin errors++; $display("FAIL read_m_error got %b want 00", m_error); end
      m_req = 2'b00;
      @(negedge clk);
      checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL read_ack_pulse got %b want 00", m_ack); end
      checks++; if (m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata_hold got %h want deadbeef", m_rdata); end
      @(negedge clk);
   endtask

   task automatic test_contention();
      int cyc;
      logic [1:0] exp_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      apply_reset();
      slave_en   = 1'b1;
      slave_wait = 0;
      m_write    = 2'b00;
      m_addr     = {32'h0000_2000, 32'h0000_1000};
      m_req      = 2'b11;
      for (int k = 0; k < 4; k++) begin
         slave_rdata = 32'hA000_0000 + k;
         wait_ack(20, cyc);
         checks++; if (m_ack !== exp_ack[k]) begin errors++; $display("FAIL contention_order[%0d] got %b want %b", k, m_ack, exp_ack[k]); end
         checks++; if (cyc !== ((k == 0) ? 2 : 3)) begin errors++; $display("FAIL contention_spacing[%0d] got %0d want %0d", k, cyc, (k == 0) ? 2 : 3); end
         checks++; if (m_rdata !== 32'hA000_0000 + k) begin errors++; $display("FAIL contention_rdata[%0d] got %h want %h", k, m_rdata, 32'hA000_0000 + k); end
      end
      m_req = 2'b00;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_error();
      int cyc;
      slave_en    = 1'b1;
      slave_wait  = 1;
      slave_rdata = 32'hCAFEF00D;
      slave_err   = 1'b1;
      m_write     = 2'b10;
      m_addr[AW +: AW]  = 32'hFFFF_0000;
      m_wdata[DW +: DW] = 32'h1234_5678;
      m_req       = 2'b10;
      @(negedge clk);
      checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL error_grant_id got %0d want 1", grant_id); end
      checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL error_s_write got %b want 1", s_write); end
      checks++; if (s_addr !== 32'hFFFF_0000) begin errors++; $display("FAIL error_s_addr got %h want ffff0000", s_addr); end
      checks++; if (s_wdata !== 32'h1234_5678) begin errors++; $display("FAIL error_s_wdata got %h want 12345678", s_wdata); end
      wait_ack(20, cyc);
      checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL error_m_ack got %b want 10 (cyc %0d)", m_ack, cyc); end
      checks++; if (m_error !== 2'b10) begin errors++; $display("FAIL error_m_error got %b want 10", m_error); end
      checks++; if (m_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL error_write_rdata got %h want cafef00d", m_rdata); end
      m_req = 2'b00;
      @(negedge clk);
      checks++; if (m_error !== 2'b00) begin errors++; $display("FAIL error_clear got %b want 00", m_error); end
      slave_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_busy();
      int cyc;
      slave_en    = 1'b0;
      slave_rdata = 32'h5555_AAAA;
      m_write     = 2'b10;
      m_addr      = {32'h0000_BBBB, 32'h0000_AAAA};
      m_req       = 2'b10;
      @(negedge clk);
      checks++; if (s_req !== 1'b1 || grant_id !== 1'b1) begin errors++; $display("FAIL midbusy_pre got s_req=%b gid=%0d want 1/1", s_req, grant_id); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL midbusy_s_req got %b want 0", s_req); end
      checks++; if (s_write !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin errors++; $display("FAIL midbusy_s_bus got w=%b a=%h d=%h want 0", s_write, s_addr, s_wdata); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL midbusy_grant_id got %0d want 0", grant_id); end
      checks++; if (m_rdata !== 32'h0 || m_ack !== 2'b00 || m_error !== 2'b00) begin errors++; $display("FAIL midbusy_m_side got r=%h a=%b e=%b want 0", m_rdata, m_ack, m_error); end
      @(negedge clk);
      rst      = 1'b1;
      slave_en = 1'b1;
      slave_wait = 0;
      m_write  = 2'b00;
      m_req    = 2'b11;
      @(negedge clk);
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL midbusy_first_winner got %0d want 0", grant_id); end
      checks++; if (s_addr !== 32'h0000_AAAA) begin errors++; $display("FAIL midbusy_first_addr got %h want 0000aaaa", s_addr); end
      wait_ack(20, cyc);
      checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL midbusy_ack got %b want 01 (cyc %0d)", m_ack, cyc); end
      checks++; if (m_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL midbusy_rdata got %h want 5555aaaa", m_rdata); end
      m_req = 2'b00;
      @(negedge clk);
      @(negedge clk);
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      slave_en = 1'b0;
      m_req    = 2'b01;
      wait_ack(30, cyc);
      checks++; if (cyc !== 9) begin errors++; $display("FAIL timeout_latency got %0d want 9", cyc); end
      checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL timeout_m_ack got %b want 01", m_ack); end
      checks++; if (m_error !== 2'b01) begin errors++; $display("FAIL timeout_m_error got %b want 01", m_error); end
      checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL timeout_m_rdata got %h want 0", m_rdata); end
      m_req = 2'b00;
      @(negedge clk);
      @(negedge clk);
   endtask
`else
   task automatic test_no_timeout();
      int low_cycles = 0;
      int ack_cycles = 0;
      slave_en = 1'b0;
      m_req    = 2'b01;
      @(negedge clk);
      for (int c = 0; c < 120; c++) begin
         if (s_req !== 1'b1) low_cycles++;
         if (m_ack !== 2'b00) ack_cycles++;
         @(negedge clk);
      end
      checks++; if (low_cycles !== 0) begin errors++; $display("FAIL no_timeout_s_req low for %0d cycles want 0", low_cycles); end
      checks++; if (ack_cycles !== 0) begin errors++; $display("FAIL no_timeout_m_ack seen %0d cycles want 0", ack_cycles); end
      apply_reset();
   endtask
`endif

   initial begin
      rst         = 1'b0;
      m_req       = '0;
      m_write     = '0;
      m_addr      = '0;
      m_wdata     = '0;
      slave_en    = 1'b0;
      slave_wait  = 0;
      slave_rdata = '0;
      slave_err   = 1'b0;
      test_reset();
      test_single_read();
      test_contention();
      test_error();
      test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
